izh_scheduler: RTL
==================

# izh_scheduler

Time-multiplexing controller that shares one Izhikevich update datapath across `N` neurons. The block holds per-neuron membrane (`v`) and recovery (`u`) state and latches per-neuron input currents on each timestep `tick`. It then issues one update request per neuron, in index order, to the shared update unit over a valid/ready handshake and writes each returned result back. At the end of the timestep it publishes the spike vector and a done pulse. It sits between the top-level I/O wrapper and the single shared neuron-update unit.

## Interface
- `N` — 4 — number of neurons, 2..16
- `W` — 16 — signed width of `v`/`u`
- `V_INIT` — 16'shFFBF (−65) — reset/initial `v`
- `U_INIT` — 16'shFFF3 (−13) — reset/initial `u`

- `clk` in 1 — single clock, rising edge
- `reset` in 1 — asynchronous, active-high reset
- `tick` in 1 — start-of-timestep strobe
- `current_in` in N*8 — unsigned currents; neuron i is bits [8i+7:8i]
- `upd_valid` out 1 — request to update unit
- `upd_ready` in 1 — update unit accepts the request
- `upd_idx` out 4 — neuron index of the request
- `upd_v`, `upd_u` out W — current state of neuron `upd_idx`
- `upd_current` out 16 — `{8'b0, latched current}`
- `res_valid` in 1 — result strobe from update unit
- `res_v`, `res_u` in W — new state
- `res_spike` in 1 — neuron fired this step
- `spike_vec` out N — spikes from the last completed step
- `step_done` out 1 — one-cycle pulse at step completion
- `busy` out 1 — high in any state other than IDLE
- `overrun` out 1 — sticky: `tick` arrived while busy
- `mon_sel` in 4 — monitor select
- `mon_v` out W — `v` of neuron `mon_sel`, combinational read; returns 0 if `mon_sel` ≥ N

## Operation
- State arrays `v_mem[N]`, `u_mem[N]`, and current latch `cur[N]` are registers.
- FSM states:
  - IDLE
    - `tick` → latch all `current_in` into `cur`.
    - `idx` ← 0; spike accumulator ← 0; go to ISSUE.
  - ISSUE
    - `upd_valid` = 1, with `upd_idx`/`upd_v`/`upd_u`/`upd_current` driven from `idx`.
    - `upd_valid && upd_ready` → go to WAIT.
    - Request fields are stable while `upd_valid` is high and `upd_ready` is low.
  - WAIT
    - `upd_valid` = 0.
    - `res_valid` → `v_mem[idx]` ← `res_v`, `u_mem[idx]` ← `res_u`, `acc[idx]` ← `res_spike`.
    - If `idx == N-1` → go to DONE; else `idx++` and go to ISSUE.
  - DONE
    - `spike_vec` ← `acc`; `step_done` = 1 for this cycle; go to IDLE.
- `res_valid` outside WAIT is ignored (no state write).
- `tick` outside IDLE is not queued: `overrun` ← 1 and the step in progress continues unaffected.
- `spike_vec` holds its value until the next DONE.
- `mon_v` reads the stored state, reflecting the writes of the completed step.
- Arithmetic: none in this block; values pass through unmodified. `upd_current` is a zero-extension.

## Timing
- Reset (asynchronous, any state):
  - FSM → IDLE, `idx` = 0.
  - All `v_mem` = `V_INIT`, all `u_mem` = `U_INIT`, all `cur` = 0.
  - `upd_valid`, `step_done`, `busy`, `overrun` = 0; `spike_vec` = 0.
- Reset mid-step abandons the step. No partial `spike_vec` or `step_done` is produced.
- `tick` sampled at edge T → `upd_valid` high from cycle T+1.
- Per-neuron cost is 1 ISSUE cycle, plus ready stall, plus cycles in WAIT until `res_valid`. `res_valid` may arrive in the cycle after acceptance at the earliest.
- With `upd_ready`=1 and a one-cycle result, `step_done` is high at cycle T+2N+1, and `spike_vec` is updated on that same edge.
- `busy` is high from T+1 through the DONE cycle inclusive.
- A `tick` coincident with the DONE cycle sets `overrun` and is dropped. A `tick` in the IDLE cycle after DONE is accepted.

## Test plan
- Reset check: assert `reset` mid-ISSUE.
  - Required: `upd_valid`/`busy` drop immediately (asynchronous).
  - Required: `mon_v` with `mon_sel`=2 reads −65, `spike_vec`=0, `overrun`=0.
- Full step, N=4, model update unit with `upd_ready`=1, one-cycle result, `res_spike` = (idx==1 || idx==3), `current_in`=32'h40302010.
  - Required: requests carry `upd_idx` 0,1,2,3 with `upd_current` 0x10,0x20,0x30,0x40.
  - Required: `step_done` at T+9; `spike_vec`=4'b1010.
- Backpressure: hold `upd_ready`=0 for 5 cycles on idx 2.
  - Required: `upd_valid` stays high and `upd_idx`/`upd_v`/`upd_u` stay stable during the stall.
  - Required: `step_done` slips by exactly 5 cycles.
- Writeback: model returns `res_v` = 100+idx.
  - Required: after `step_done`, `mon_v` for `mon_sel`=0..3 reads 100..103.
  - Required: `mon_sel`=7 reads 0.
- Overrun/stray: pulse `tick` during WAIT and `res_valid` during ISSUE.
  - Required: `overrun`=1 and stays set.
  - Required: stored state is unchanged by the stray result, and only one `step_done` is produced.
- Current latch: change `current_in` after `tick`.
  - Required: all requests in that step carry the currents latched at `tick`.

Source files
------------

// File: rtl/izh_scheduler.sv
// izh_scheduler: shares one Izhikevich update unit across N neurons.
// It latches the input currents on tick, then issues one request per neuron
// in index order over valid/ready, writes each result back, and publishes
// the spike vector together with a done pulse.
module izh_scheduler #(
  parameter int unsigned         N      = 4,
  parameter int unsigned         W      = 16,
  parameter logic signed [W-1:0] V_INIT = 16'shFFBF,
  parameter logic signed [W-1:0] U_INIT = 16'shFFF3
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                tick,
  input  logic [N*8-1:0]      current_in,
  output logic                upd_valid,
  input  logic                upd_ready,
  output logic [3:0]          upd_idx,
  output logic signed [W-1:0] upd_v,
  output logic signed [W-1:0] upd_u,
  output logic [15:0]         upd_current,
  input  logic                res_valid,
  input  logic signed [W-1:0] res_v,
  input  logic signed [W-1:0] res_u,
  input  logic                res_spike,
  output logic [N-1:0]        spike_vec,
  output logic                step_done,
  output logic                busy,
  output logic                overrun,
  input  logic [3:0]          mon_sel,
  output logic signed [W-1:0] mon_v
);

  localparam int unsigned IW = $clog2(N);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t                r_state;
  state_t                w_next;
  logic [IW-1:0]         r_idx;
  logic signed [W-1:0]   r_v_mem [N];
  logic signed [W-1:0]   r_u_mem [N];
  logic [7:0]            r_cur   [N];
  logic [N-1:0]          r_acc;
  logic [N-1:0]          r_spike_vec;
  logic                  r_overrun;
  logic                  w_last;
  logic [N-1:0]          w_acc_next;

  assign w_last      = (r_idx == IW'(N - 1));
  assign upd_idx     = 4'(r_idx);
  assign upd_v       = r_v_mem[r_idx];
  assign upd_u       = r_u_mem[r_idx];
  assign upd_current = {8'b0, r_cur[r_idx]};
  assign spike_vec   = r_spike_vec;
  assign overrun     = r_overrun;

  // Spike accumulator including the result arriving this cycle.
  always_comb begin
    w_acc_next        = r_acc;
    w_acc_next[r_idx] = res_spike;
  end

  // Combinational monitor read; unmapped selects read as zero.
  always_comb begin
    mon_v = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (mon_sel == 4'(i)) mon_v = r_v_mem[i];
    end
  end

  // FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // FSM next-state and handshake/status outputs.
  always_comb begin
    w_next    = r_state;
    upd_valid = 1'b0;
    step_done = 1'b0;
    busy      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (tick) w_next = S_ISSUE;
      end
      S_ISSUE: begin
        busy      = 1'b1;
        upd_valid = 1'b1;
        if (upd_ready) w_next = S_WAIT;
      end
      S_WAIT: begin
        busy = 1'b1;
        if (res_valid) w_next = w_last ? S_DONE : S_ISSUE;
      end
      S_DONE: begin
        busy      = 1'b1;
        step_done = 1'b1;
        w_next    = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Neuron state, current latch, index, spike accumulation and overrun flag.
  // spike_vec is loaded on the edge entering DONE so it is already valid
  // while step_done is high.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_idx       <= '0;
      r_acc       <= '0;
      r_spike_vec <= '0;
      r_overrun   <= 1'b0;
      for (int unsigned i = 0; i < N; i++) begin
        r_v_mem[i] <= V_INIT;
        r_u_mem[i] <= U_INIT;
        r_cur[i]   <= '0;
      end
    end else begin
      if (tick && r_state != S_IDLE) r_overrun <= 1'b1;
      if (r_state == S_IDLE && tick) begin
        r_idx <= '0;
        r_acc <= '0;
        for (int unsigned i = 0; i < N; i++) begin
          r_cur[i] <= current_in[8*i +: 8];
        end
      end
      if (r_state == S_WAIT && res_valid) begin
        r_v_mem[r_idx] <= res_v;
        r_u_mem[r_idx] <= res_u;
        r_acc          <= w_acc_next;
        if (w_last) r_spike_vec <= w_acc_next;
        else        r_idx       <= r_idx + IW'(1);
      end
    end
  end

endmodule
